// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8-register datapath.
// Captures a 9-bit instruction {op, rx, ry} on run while idle. It then drives
// the register file, A, G and bus control lines over one cycle (mv, mvi) or
// three cycles (add, xor, sub). The final cycle of each instruction pulses
// done. Every output is decoded from the state register and the instruction
// register only, so run and instr have no combinational path to any output.
module datapath_ctrl #(
    parameter int IW   = 9,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [IW-1:0]   instr,
    output logic [SELW-1:0] reg_x_num,
    output logic [SELW-1:0] reg_y_num,
    output logic [1:0]      AddXor,
    output logic            A_in,
    output logic            G_in,
    output logic            G_out,
    output logic            Extern,
    output logic            R_in,
    output logic            done,
    output logic            busy,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ir;
    logic            r_ill;

    logic [2:0]      w_op;
    logic [SELW-1:0] w_rx;
    logic [SELW-1:0] w_ry;
    logic [1:0]      w_alu_sel;
    logic            w_is_alu;

    // Opcodes 000..100 are defined; 101..111 are rejected at capture.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

    // Map the ALU opcodes onto the AddXor encoding (00 add, 01 xor, 10 sub).
    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        case (op)
            OP_XOR:  code = 2'b01;
            OP_SUB:  code = 2'b10;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    assign w_op      = r_ir[8:6];
    assign w_rx      = SELW'(r_ir[5:3]);
    assign w_ry      = SELW'(r_ir[2:0]);
    assign w_is_alu  = (w_op == OP_ADD) || (w_op == OP_XOR) || (w_op == OP_SUB);
    assign w_alu_sel = alu_code(w_op);

    // State, instruction register and illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ill   <= (r_state == S_IDLE) && run && !op_legal(instr[8:6]);
            if ((r_state == S_IDLE) && run) begin
                r_ir <= instr;
            end
        end
    end

    // Next-state selection and control-line decode from state and IR.
    always_comb begin
        w_next    = r_state;
        reg_x_num = '0;
        reg_y_num = '0;
        AddXor    = 2'b00;
        A_in      = 1'b0;
        G_in      = 1'b0;
        G_out     = 1'b0;
        Extern    = 1'b0;
        R_in      = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        illegal   = r_ill;

        case (r_state)
            S_IDLE: begin
                if (run && op_legal(instr[8:6])) begin
                    w_next = S_T1;
                end
            end
            S_T1: begin
                if (w_op == OP_MV) begin
                    reg_x_num = w_rx;
                    reg_y_num = w_ry;
                    R_in      = 1'b1;
                    done      = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_op == OP_MVI) begin
                    reg_x_num = w_rx;
                    Extern    = 1'b1;
                    R_in      = 1'b1;
                    done      = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_is_alu) begin
                    reg_y_num = w_rx;
                    A_in      = 1'b1;
                    AddXor    = w_alu_sel;
                    w_next    = S_T2;
                end else begin
                    w_next    = S_IDLE;
                end
            end
            S_T2: begin
                reg_y_num = w_ry;
                G_in      = 1'b1;
                AddXor    = w_alu_sel;
                w_next    = S_T3;
            end
            S_T3: begin
                reg_x_num = w_rx;
                G_out     = 1'b1;
                R_in      = 1'b1;
                done      = 1'b1;
                AddXor    = w_alu_sel;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
